// File: rtl/simplez_uart_tx_if.sv
// simplez_uart_tx_if: slice of the Simplez CPU data bus seen by the UART transmitter.
interface simplez_uart_tx_if #(
  parameter int unsigned DATAW = 12,
  parameter int unsigned ADDRW = 9
);
  logic [ADDRW-1:0] addr;
  logic             wr;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;

  modport master (output addr, output wr, output data_in, input data_out);
  modport slave  (input addr, input wr, input data_in, output data_out);
endinterface

// File: rtl/simplez_uart_tx.sv
// simplez_uart_tx: memory-mapped 8N1 UART transmitter on the Simplez data bus.
// Define SIMPLEZ_UART_TX_DBUF_EN to add a one-byte holding register for gapless frames.
module simplez_uart_tx #(
  parameter int unsigned      DATAW     = 12,
  parameter int unsigned      ADDRW     = 9,
  parameter int unsigned      BAUD_DIV  = 104,
  parameter logic [ADDRW-1:0] ADDR_DATA = 9'd511,
  parameter logic [ADDRW-1:0] ADDR_STAT = 9'd510
) (
  input  logic             clk,
  input  logic             rstn,
  simplez_uart_tx_if.slave bus,
  output logic             tx
);

  localparam int unsigned DIVW    = $clog2(BAUD_DIV);
  localparam int unsigned DIV_MAX = BAUD_DIV - 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       frame_q, frame_d;
  logic             ovr_q, ovr_d;
  logic             tx_d;
  logic [DATAW-1:0] dout_q, dout_d;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`endif

  logic       wr_data, wr_stat, ready, busy, accept, baud_tick;
  logic [7:0] wr_byte;
  logic       unused_data_hi;

  assign wr_data        = bus.wr && (bus.addr == ADDR_DATA);
  assign wr_stat        = bus.wr && (bus.addr == ADDR_STAT);
  assign wr_byte        = bus.data_in[7:0];
  assign unused_data_hi = ^bus.data_in[DATAW-1:8];
  assign busy           = (state_q != S_IDLE);
  assign baud_tick      = (div_q == DIVW'(DIV_MAX));
  assign accept         = wr_data && ready;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
  assign ready          = !hold_full_q;
`else
  assign ready          = (state_q == S_IDLE);
`endif
  assign bus.data_out   = dout_q;

  // Next-state, datapath and registered-output logic; tx follows state one cycle later
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    bit_d   = bit_q;
    frame_d = frame_q;
    ovr_d   = ovr_q;
    tx_d    = 1'b1;
    dout_d  = '0;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    if (state_q != S_IDLE) div_d = baud_tick ? '0 : div_q + DIVW'(1);

    if (wr_stat)                ovr_d = 1'b0;
    else if (wr_data && !ready) ovr_d = 1'b1;

`ifdef SIMPLEZ_UART_TX_DBUF_EN
    if (accept && (state_q != S_IDLE)) begin
      hold_d      = wr_byte;
      hold_full_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          frame_d = wr_byte;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx_d = frame_q[bit_q];
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
`ifdef SIMPLEZ_UART_TX_DBUF_EN
          // A byte written on the completing edge bypasses the empty holding register
          if (hold_full_q) begin
            state_d     = S_START;
            frame_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            state_d     = S_START;
            frame_d     = wr_byte;
            hold_full_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.addr == ADDR_STAT) dout_d = DATAW'({ovr_q, busy, ready});
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      tx      <= 1'b1;
      dout_q  <= '0;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      tx      <= tx_d;
      dout_q  <= dout_d;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_simplez_uart_tx.sv
// tb_simplez_uart_tx: self-checking bench for the Simplez UART transmitter with a frame-level model.
module tb_simplez_uart_tx;

  localparam int unsigned B      = 4;
  localparam logic [8:0]  A_DATA = 9'd511;
  localparam logic [8:0]  A_STAT = 9'd510;
  localparam int unsigned FRAME  = 10 * B;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic tx;
  int   checks = 0;
  int   errors = 0;

  simplez_uart_tx_if #(.DATAW(12), .ADDRW(9)) bus ();

  simplez_uart_tx #(
    .DATAW(12), .ADDRW(9), .BAUD_DIV(B), .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .tx(tx)
  );

  always #5 clk = ~clk;

  // Line level of bit slot idx (0 start, 1..8 data LSB first, 9 stop) of an 8N1 frame
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic bus_idle();
    bus.addr = '0; bus.wr = 1'b0; bus.data_in = '0;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [11:0] d);
    bus.addr = a; bus.wr = 1'b1; bus.data_in = d;
  endtask

  task automatic bus_read(input logic [8:0] a);
    bus.addr = a; bus.wr = 1'b0; bus.data_in = '0;
  endtask

  task automatic chk_tx(input string tag, input int k, input logic exp);
    checks++;
    if (tx !== exp) begin
      errors++;
      $display("FAIL %s tx at cycle %0d: got %b expected %b", tag, k, tx, exp);
    end
  endtask

  task automatic chk_dout(input string tag, input logic [11:0] exp);
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL %s data_out: got %h expected %h", tag, bus.data_out, exp);
    end
  endtask

  // Sends one word from a negedge and checks the frame, mid-frame status and final status
  task automatic send_and_check(input logic [11:0] word, input string tag);
    logic [11:0] mid_stat;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
    mid_stat = 12'h003;
`else
    mid_stat = 12'h002;
`endif
    bus_write(A_DATA, word);
    @(negedge clk);
    bus_read(A_STAT);
    for (int k = 1; k <= int'(FRAME) + 2; k++) begin
      @(negedge clk);
      chk_tx(tag, k, (k <= int'(FRAME)) ? frame_bit(word[7:0], (k-1)/B) : 1'b1);
      if (k == 5*B) chk_dout({tag, " mid status"}, mid_stat);
    end
    chk_dout({tag, " end status"}, 12'h001);
  endtask

  task automatic test_reset();
    bus_read(A_STAT);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_tx("reset", 0, 1'b1);
    chk_dout("reset dout", 12'h000);
    rstn = 1'b1;
    bus_idle();
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      chk_tx("idle", k, 1'b1);
    end
    chk_dout("idle unmapped 0", 12'h000);
    bus_read(A_STAT);
    @(negedge clk);
    chk_dout("idle status", 12'h001);
    bus_read(9'($urandom_range(1, 509)));
    @(negedge clk);
    chk_dout("idle unmapped rnd", 12'h000);
    bus_read(A_DATA);
    @(negedge clk);
    chk_dout("data addr read", 12'h000);
  endtask

  task automatic test_read_latency();
    bus_read(9'd0);
    @(negedge clk);
    chk_dout("latency addr0", 12'h000);
    bus_read(A_STAT);
    #2;
    chk_dout("latency before edge", 12'h000);
    @(negedge clk);
    chk_dout("latency after edge", 12'h001);
    bus_read(9'd0);
    @(negedge clk);
    chk_dout("latency back to 0", 12'h000);
  endtask

  task automatic test_single_byte();
    send_and_check(12'hF55, "single F55");
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 5; i++) send_and_check(12'($urandom), "random");
  endtask

`ifndef SIMPLEZ_UART_TX_DBUF_EN
  task automatic test_overrun();
    bus_write(A_DATA, 12'h041);
    @(negedge clk);
    bus_idle();
    for (int k = 1; k <= int'(FRAME) + 10; k++) begin
      @(negedge clk);
      chk_tx("overrun", k, (k <= int'(FRAME)) ? frame_bit(8'h41, (k-1)/B) : 1'b1);
      case (k)
        1:  bus_write(A_DATA, 12'h042);
        2:  bus_read(A_STAT);
        3:  chk_dout("ovr set", 12'h006);
        20: begin
              chk_dout("ovr mid", 12'h006);
              bus_write(A_STAT, 12'($urandom));
            end
        21: begin
              chk_dout("ovr before clear", 12'h006);
              bus_read(A_STAT);
            end
        22: chk_dout("ovr cleared", 12'h002);
        42: chk_dout("ovr end", 12'h001);
        default: ;
      endcase
    end
  endtask
`else
  task automatic test_back_to_back();
    logic exp;
    bus_write(A_DATA, 12'h0AA);
    @(negedge clk);
    bus_idle();
    for (int k = 1; k <= 2*int'(FRAME) + 2; k++) begin
      @(negedge clk);
      if (k <= int'(FRAME))        exp = frame_bit(8'hAA, (k-1)/B);
      else if (k <= 2*int'(FRAME)) exp = frame_bit(8'h55, (k-1-int'(FRAME))/B);
      else                         exp = 1'b1;
      chk_tx("b2b", k, exp);
      case (k)
        1:  bus_write(A_DATA, 12'h055);
        2:  bus_read(A_STAT);
        3:  chk_dout("b2b held", 12'h002);
        40: chk_dout("b2b held late", 12'h002);
        42: chk_dout("b2b moved", 12'h003);
        82: chk_dout("b2b end", 12'h001);
        default: ;
      endcase
    end
  endtask
`endif

  // Write landing exactly on the stop-bit completion edge
  task automatic test_write_at_frame_end();
    logic exp;
    logic [11:0] after_stat;
`ifdef SIMPLEZ_UART_TX_DBUF_EN
    after_stat = 12'h003;
`else
    after_stat = 12'h005;
`endif
    bus_write(A_DATA, 12'h033);
    @(negedge clk);
    bus_idle();
    for (int k = 1; k <= 2*int'(FRAME) + 4; k++) begin
      @(negedge clk);
      if (k <= int'(FRAME)) exp = frame_bit(8'h33, (k-1)/B);
`ifdef SIMPLEZ_UART_TX_DBUF_EN
      else if (k <= 2*int'(FRAME)) exp = frame_bit(8'h0C, (k-1-int'(FRAME))/B);
`endif
      else exp = 1'b1;
      chk_tx("frame end write", k, exp);
      case (k)
        39: bus_write(A_DATA, 12'hA0C);
        40: bus_read(A_STAT);
        41: chk_dout("frame end status", after_stat);
        82: bus_write(A_STAT, 12'h000);
        83: bus_read(A_STAT);
        84: chk_dout("frame end cleared", 12'h001);
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] word;
    word = 12'($urandom) & 12'hFF7;
    bus_write(A_DATA, word);
    @(negedge clk);
    bus_idle();
    for (int k = 1; k <= 4*int'(B) + 2; k++) begin
      @(negedge clk);
      chk_tx("pre-reset", k, frame_bit(word[7:0], (k-1)/B));
    end
    #2 rstn = 1'b0;
    #1;
    chk_tx("async reset", 0, 1'b1);
    repeat (2) @(negedge clk);
    chk_tx("in reset", 0, 1'b1);
    rstn = 1'b1;
    bus_read(A_STAT);
    @(negedge clk);
    chk_dout("after reset status", 12'h001);
    send_and_check(12'($urandom), "post-reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    test_reset();
    test_read_latency();
    test_single_byte();
    test_random_frames();
`ifndef SIMPLEZ_UART_TX_DBUF_EN
    test_overrun();
`else
    test_back_to_back();
`endif
    test_write_at_frame_end();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simplez_uart_tx.md
# simplez_uart_tx

Memory-mapped UART transmitter peripheral on the Simplez microcontroller data bus, downstream of the CPU's ST path. The CPU writes a byte to the data address. The block serialises it as 8N1 on `tx`. The CPU polls a status word at the neighbouring address to learn when the next write will be accepted. Bus widths match the CPU: 12-bit data, 9-bit addresses.

## Interface
- `DATAW`, 12, bus data width
- `ADDRW`, 9, bus address width
- `BAUD_DIV`, 104, clock cycles per serial bit; legal range is ≥2 (104 gives 115200 baud at 12 MHz)
- `ADDR_DATA`, 9'd511, address of the transmit data register (write-only)
- `ADDR_STAT`, 9'd510, address of the status register (read; a write clears overrun)

Ports:
- `clk` input 1: system clock; one clock domain, all state on rising edge
- `rstn` input 1: asynchronous, active-low reset
- `addr` input ADDRW: bus address from the CPU
- `wr` input 1: write strobe; sampled on `clk` rising edge
- `data_in` input DATAW: write data
- `data_out` output DATAW: registered read data
- `tx` output 1: serial line, idle high

## Operation
- Reset values:
  - `tx`=1 and `data_out`=0.
  - FSM is in IDLE; divider and bit counter are 0.
  - Overrun flag is 0; holding register is empty.
- Status word (read at ADDR_STAT): bit0 `ready`, bit1 `busy` (FSM not IDLE), bit2 `ovr` (sticky). Bits 11:3 read 0.
- Reads at any other address return 0, so the block can be OR-ed onto the CPU read mux.
- Write to ADDR_DATA with `ready`=1: `data_in[7:0]` is accepted; `data_in[11:8]` is ignored.
- Write to ADDR_DATA with `ready`=0: the byte is dropped and `ovr` is set to 1.
- Write to ADDR_STAT, any data: clears `ovr`.
- FSM states:
  - IDLE: `tx`=1. On an accepted byte, go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles. Bit counter runs 0..7; after bit 7, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles. Then go to IDLE, or directly to START if a byte is pending (see Configuration).
- Baud divider:
  - Counts 0..BAUD_DIV-1 and is cleared on every state entry.
  - Counter width is $clog2(BAUD_DIV).
  - No cumulative drift: each bit is exactly BAUD_DIV cycles.
- `tx` is driven from a register; it is glitch-free.

## Timing
- Write accepted at edge N: `tx` is low from edge N+1. The start bit occupies cycles N+1 .. N+BAUD_DIV.
- A frame is exactly 10×BAUD_DIV cycles from the `tx` falling edge to the end of the stop bit.
- `data_out` is registered: the value for `addr` sampled at edge N appears after edge N. This matches the synchronous memory read latency.
- Status reflects write effects one cycle later. A status read issued in the cycle after a write sees the updated `ready`/`ovr`.
- Simultaneous events at one edge:
  - Write to ADDR_DATA and frame completion:
    - With buffering, the write is accepted (the holding register empties or fills in the same edge consistently).
    - Without buffering, `ready` is still 0 at that edge, so the write is an overrun.
  - Write to ADDR_STAT and an overrun in the same edge is impossible, because there is a single `addr`.
- `rstn` asserted mid-frame: `tx` goes to 1 immediately (asynchronously) and all state clears. A partial frame is abandoned.

## Configuration
- Macro `SIMPLEZ_UART_TX_DBUF_EN` enables a one-byte holding register.
- Defined:
  - `ready` = holding register empty.
  - A write while busy is stored. At the end of STOP, the FSM goes straight to START with the held byte; there are no idle cycles between frames.
  - Up to two bytes are in flight.
- Undefined:
  - `ready` = (state==IDLE).
  - A second write during a frame is an overrun.
  - At least one idle cycle follows STOP before the next START.

## Test plan
- Reset then idle: hold `rstn`=0, release, run 50 cycles → `tx`=1, status reads 12'h001, `data_out`=0 for unmapped addresses.
- Single byte, BAUD_DIV=4: write 12'hF55 to 511 → `tx` sequence over 40 cycles is 0,1,0,1,0,1,0,1,0,1 (4 cycles each), then `tx`=1 and status returns to 12'h001.
- Overrun (macro undefined): write 12'h041, then 12'h042 two cycles later → only 0x41 is sent, status=12'h006 during the frame. Write to 510 → `ovr` clears, status=12'h002.
- Back-to-back (macro defined): write 12'h0AA, then 12'h055 while busy → frames are contiguous, with the stop bit immediately followed by the start bit. Status reads 12'h002 while holding is full, then 12'h003 once the held byte moves to the shifter. No overrun.
- Reset mid-frame: assert `rstn` at bit 3 of a frame → `tx`=1 within the same cycle, status=12'h001 after release. A new write transmits a correct frame.
- Read latency: read 510 at edge N → status is on `data_out` after edge N. Read 0 → `data_out`=0.
